// File: rtl/wb_bram_burst_if.sv
// Wishbone B4 bus bundle for the burst block-RAM slave.
// Clock and reset travel with the bus so the slave has a single port.
interface wshb_if;
  logic        clk;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    input  clk, rst, dat_sm, ack, err, rty,
    output cyc, stb, we, adr, sel, dat_ms, cti, bte
  );

  modport slave (
    input  clk, rst, cyc, stb, we, adr, sel, dat_ms, cti, bte,
    output dat_sm, ack, err, rty
  );
endinterface

// File: rtl/wb_bram_burst.sv
// Wishbone B4 block-RAM slave: single-cycle byte-lane writes, registered
// reads, and incrementing/wrapping read bursts at one word per cycle.
module wb_bram_burst #(
  parameter int mem_adr_width = 11,
  parameter bit wrap_enable   = 1'b1
) (
  wshb_if.slave wb_s
);

  localparam int depth = 2 ** mem_adr_width;

  typedef enum logic {IDLE, RD} state_t;

  logic [31:0]              mem [depth];
  state_t                   state;
  logic                     ready;
  logic [mem_adr_width-1:0] pend;
  logic                     pend_oor;
  logic [31:0]              dat_q;

  logic                     req;
  logic [mem_adr_width-1:0] adr_idx;
  logic                     adr_oor;
  logic [mem_adr_width-1:0] nxt;
  logic                     wr_go;
  logic                     rd_go;
  logic                     unused_adr;

  // Next word index: linear increments the whole index (wrapping at the top
  // of memory); wrap-N increments only the low bits selected by the mask.
  function automatic logic [mem_adr_width-1:0] next_idx(
    input logic [mem_adr_width-1:0] w,
    input logic [1:0]               b
  );
    logic [mem_adr_width-1:0] m;
    // NOTE: every variable gets a value before any branch, so no path leaves it undriven (no latch).
    m = '1;
    if (wrap_enable) begin
      case (b)
        2'b01:   m = mem_adr_width'(4'h3);
        2'b10:   m = mem_adr_width'(4'h7);
        2'b11:   m = mem_adr_width'(4'hF);
        default: m = '1;
      endcase
    end
    return (w & ~m) | ((w + mem_adr_width'(1)) & m);
  endfunction

  assign req        = wb_s.cyc & wb_s.stb;
  assign adr_idx    = wb_s.adr[mem_adr_width+1:2];
  assign adr_oor    = |wb_s.adr[31:mem_adr_width+2];
  assign nxt        = next_idx(pend, wb_s.bte);
  assign unused_adr = &{1'b0, wb_s.adr[1:0]};

  // ready stays low through reset and the first cycle after it, masking
  // any termination in that window.
  assign wr_go = ~wb_s.rst & ready & (state == IDLE) & req & wb_s.we;
  assign rd_go = ~wb_s.rst & ready & (state == RD) & req & ~wb_s.we;

  assign wb_s.ack    = (wr_go & ~adr_oor) | (rd_go & ~pend_oor);
  assign wb_s.err    = (wr_go & adr_oor) | (rd_go & pend_oor);
  assign wb_s.rty    = 1'b0;
  assign wb_s.dat_sm = dat_q;

  // NOTE: the array has no reset branch so it maps onto block RAM; contents are undefined until written.
  always_ff @(posedge wb_s.clk) begin
    if (wr_go && !adr_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_s.sel[b]) mem[adr_idx][8*b +: 8] <= wb_s.dat_ms[8*b +: 8];
      end
    end
  end

  always_ff @(posedge wb_s.clk) begin
    // NOTE: non-blocking assignments keep every register reading pre-edge values regardless of statement order.
    if (wb_s.rst) begin
      state    <= IDLE;
      ready    <= 1'b0;
      dat_q    <= '0;
      pend     <= '0;
      pend_oor <= 1'b0;
    end else begin
      ready <= 1'b1;
      case (state)
        IDLE: begin
          if (ready && req && !wb_s.we) begin
            dat_q    <= adr_oor ? '0 : mem[adr_idx];
            pend     <= adr_idx;
            pend_oor <= adr_oor;
            state    <= RD;
          end
        end
        RD: begin
          if (!wb_s.cyc) begin
            state <= IDLE;
          end else if (wb_s.stb && wb_s.we) begin
            // Mode switch mid-burst: drop the read, the write is taken from IDLE.
            state <= IDLE;
          end else if (wb_s.stb) begin
            if (wb_s.cti == 3'b010) begin
              dat_q <= pend_oor ? '0 : mem[nxt];
              pend  <= nxt;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bram_burst.sv
// Directed bench for wb_bram_burst: table of single accesses plus
// hand-written burst, wait-state and reset-in-burst sequences.
module tb_wb_bram_burst;

  wshb_if bus ();

  wb_bram_burst dut (.wb_s(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[15];
  int   seq[16];

  initial bus.clk = 1'b0;
  always #5 bus.clk = ~bus.clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic idle_bus();
    bus.cyc    = 1'b0;
    bus.stb    = 1'b0;
    bus.we     = 1'b0;
    bus.adr    = '0;
    bus.sel    = 4'h0;
    bus.dat_ms = '0;
    bus.cti    = 3'b000;
    bus.bte    = 2'b00;
  endtask

  task automatic do_write(input string name, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input logic exp_err);
    @(posedge bus.clk); #1;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1;
    bus.adr = adr; bus.sel = sel; bus.dat_ms = dat; bus.cti = 3'b000;
    @(negedge bus.clk);
    check1({name, " ack"}, bus.ack, ~exp_err);
    check1({name, " err"}, bus.err, exp_err);
    @(posedge bus.clk); #1;
    idle_bus();
  endtask

  task automatic do_read(input string name, input logic [31:0] adr, input logic exp_err,
                         input logic [31:0] exp_dat);
    @(posedge bus.clk); #1;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0;
    bus.adr = adr; bus.sel = 4'hF; bus.cti = 3'b000; bus.bte = 2'b00;
    @(negedge bus.clk);
    check1({name, " no term at N"}, bus.ack | bus.err, 1'b0);
    @(posedge bus.clk); #1;
    @(negedge bus.clk);
    check1({name, " ack N+1"}, bus.ack, ~exp_err);
    check1({name, " err N+1"}, bus.err, exp_err);
    check({name, " data"}, bus.dat_sm, exp_dat);
    @(posedge bus.clk); #1;
    idle_bus();
  endtask

  // Read burst of n beats; data equals word index after preload.
  // stb is dropped for wait_len cycles once wait_after beats are acked.
  task automatic burst(input string name, input logic [1:0] b, input int n, input int idx[16],
                       input int wait_after, input int wait_len);
    int k, cno, waited, last_ack;
    k = 0; cno = 0; waited = 0; last_ack = -1;
    @(posedge bus.clk); #1;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.sel = 4'hF; bus.bte = b;
    bus.adr = 32'(idx[0]) << 2;
    bus.cti = (n == 1) ? 3'b111 : 3'b010;
    while (k < n && cno < 64) begin
      @(negedge bus.clk);
      if (cno == 0) begin
        check1($sformatf("%s first-cycle ack", name), bus.ack, 1'b0);
      end else if (bus.stb) begin
        check1($sformatf("%s beat%0d ack", name, k), bus.ack, 1'b1);
        check1($sformatf("%s beat%0d err", name, k), bus.err, 1'b0);
        if (bus.ack) begin
          check($sformatf("%s beat%0d data", name, k), bus.dat_sm, 32'(idx[k]));
          k++;
          last_ack = cno;
        end
      end else begin
        check1($sformatf("%s wait ack", name), bus.ack, 1'b0);
        check($sformatf("%s wait hold", name), bus.dat_sm, 32'(idx[k]));
      end
      @(posedge bus.clk); #1;
      cno++;
      if (k == n) begin
        idle_bus();
      end else if (k == wait_after && waited < wait_len) begin
        bus.stb = 1'b0;
        waited++;
      end else begin
        bus.stb = 1'b1;
        bus.adr = 32'(idx[k]) << 2;
        bus.cti = (k == n - 1) ? 3'b111 : 3'b010;
      end
    end
    idle_bus();
    check($sformatf("%s last ack cycle", name), 32'(last_ack), 32'(n + wait_len));
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0000, 4'hF, 32'hA5A5_A5A5, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h0000_0014, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 32'h0000_0014, 4'hA, 32'h1234_5678, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0014, 4'hF, 32'h0,         1'b0, 32'h12FF_56FF};
    vecs[4]  = '{1'b1, 32'h0000_0014, 4'h0, 32'h0000_0000, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 32'h0000_0014, 4'h1, 32'h0000_00AA, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0014, 4'hF, 32'h0,         1'b0, 32'h12FF_56AA};
    vecs[7]  = '{1'b1, 32'h0000_2000, 4'hF, 32'hDEAD_BEEF, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         1'b0, 32'hA5A5_A5A5};
    vecs[9]  = '{1'b0, 32'h0000_2000, 4'hF, 32'h0,         1'b1, 32'h0};
    vecs[10] = '{1'b1, 32'h0000_1FFC, 4'hF, 32'h0000_07FF, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h0000_1FFC, 4'hF, 32'h0,         1'b0, 32'h0000_07FF};
    vecs[12] = '{1'b1, 32'hFFFF_FFFC, 4'hF, 32'h1111_1111, 1'b1, 32'h0};
    vecs[13] = '{1'b0, 32'h0000_1FFC, 4'hF, 32'h0,         1'b0, 32'h0000_07FF};
    vecs[14] = '{1'b0, 32'h8000_0014, 4'hF, 32'h0,         1'b1, 32'h0};

    idle_bus();
    bus.rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge bus.clk); #1;
      @(negedge bus.clk);
      check1("reset ack", bus.ack, 1'b0);
      check1("reset err", bus.err, 1'b0);
      check1("reset rty", bus.rty, 1'b0);
      check("reset dat_sm", bus.dat_sm, 32'h0);
    end
    @(posedge bus.clk); #1;
    bus.rst = 1'b0;
    @(negedge bus.clk);
    check1("post-reset ack", bus.ack, 1'b0);
    check1("post-reset err", bus.err, 1'b0);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].we)
        do_write($sformatf("vec%0d wr", i), vecs[i].adr, vecs[i].sel, vecs[i].dat, vecs[i].exp_err);
      else
        do_read($sformatf("vec%0d rd", i), vecs[i].adr, vecs[i].exp_err, vecs[i].exp_dat);
    end

    // Reset held for 3 cycles in the middle of a read burst.
    @(posedge bus.clk); #1;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.sel = 4'hF;
    bus.adr = 32'h0; bus.cti = 3'b010; bus.bte = 2'b00;
    @(posedge bus.clk); #1;
    @(negedge bus.clk);
    check1("rst-burst beat0 ack", bus.ack, 1'b1);
    @(posedge bus.clk); #1;
    bus.rst = 1'b1;
    bus.adr = 32'h4;
    for (int i = 0; i < 3; i++) begin
      @(negedge bus.clk);
      check1($sformatf("rst-burst cyc%0d ack", i), bus.ack, 1'b0);
      check1($sformatf("rst-burst cyc%0d err", i), bus.err, 1'b0);
      if (i > 0) check($sformatf("rst-burst cyc%0d dat_sm", i), bus.dat_sm, 32'h0);
      @(posedge bus.clk); #1;
    end
    bus.rst = 1'b0;
    idle_bus();
    @(negedge bus.clk);
    check1("rst-burst release ack", bus.ack, 1'b0);
    check("rst-burst release dat_sm", bus.dat_sm, 32'h0);
    do_read("after rst-burst", 32'h0000_0014, 1'b0, 32'h12FF_56AA);

    for (int i = 0; i < 16; i++)
      do_write($sformatf("preload%0d", i), 32'(i) << 2, 4'hF, 32'(i), 1'b0);

    seq = '{4, 5, 6, 7, 8, 9, 10, 11, 0, 0, 0, 0, 0, 0, 0, 0};
    burst("linear8", 2'b00, 8, seq, -1, 0);
    do_read("idle after linear8", 32'h0000_0018, 1'b0, 32'h6);

    seq = '{6, 7, 0, 1, 2, 3, 4, 5, 0, 0, 0, 0, 0, 0, 0, 0};
    burst("wrap8", 2'b10, 8, seq, -1, 0);

    seq = '{2, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    burst("wrap4", 2'b01, 4, seq, -1, 0);

    seq = '{14, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    burst("wrap16", 2'b11, 3, seq, -1, 0);

    seq = '{2047, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    burst("linear top", 2'b00, 2, seq, -1, 0);

    seq = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    burst("waitstate", 2'b00, 4, seq, 2, 2);

    @(posedge bus.clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
